// File: rtl/vga_timing_pkg.sv
// Shared types and default raster timing for the programmable VGA sequencer.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_e;

  localparam logic [2:0] SEL_H_ACT  = 3'd0;
  localparam logic [2:0] SEL_H_FP   = 3'd1;
  localparam logic [2:0] SEL_H_SYNC = 3'd2;
  localparam logic [2:0] SEL_H_BP   = 3'd3;
  localparam logic [2:0] SEL_V_ACT  = 3'd4;
  localparam logic [2:0] SEL_V_FP   = 3'd5;
  localparam logic [2:0] SEL_V_SYNC = 3'd6;
  localparam logic [2:0] SEL_V_BP   = 3'd7;

  localparam int unsigned DEF_CW       = 10;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam bit          DEF_SYNC_POL = 1'b0;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      ACT:     return FP;
      FP:      return SYNC;
      SYNC:    return BP;
      default: return ACT;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Config write/commit channel into the VGA timing controller.
interface vga_timing_ctrl_if #(
  parameter int unsigned CW = 10
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_sel;
  logic [CW-1:0] cfg_data;
  logic          cfg_commit;

  modport master (output cfg_valid, cfg_sel, cfg_data, cfg_commit, input cfg_ready);
  modport slave  (input cfg_valid, cfg_sel, cfg_data, cfg_commit, output cfg_ready);
endinterface

// File: rtl/vga_axis_seq.sv
// One raster axis: ACT/FP/SYNC/BP phase FSM with a per-phase counter.
module vga_axis_seq
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic [CW-1:0] len_act,
  input  logic [CW-1:0] len_fp,
  input  logic [CW-1:0] len_sync,
  input  logic [CW-1:0] len_bp,
  output phase_e        state,
  output logic [CW-1:0] count,
  output logic          wrap
);

  phase_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] len_cur;

  always_comb begin
    len_cur = len_bp;
    case (state_q)
      ACT:     len_cur = len_act;
      FP:      len_cur = len_fp;
      SYNC:    len_cur = len_sync;
      default: len_cur = len_bp;
    endcase

    state_d = state_q;
    count_d = count_q;
    wrap    = 1'b0;
    if (clr) begin
      state_d = ACT;
      count_d = '0;
    end else if (adv) begin
      if (count_q == len_cur - CW'(1)) begin
        count_d = '0;
        state_d = next_phase(state_q);
        // wrap marks the end of the whole 4-phase cycle, not each phase
        wrap    = (state_q == BP);
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state = state_q;
  assign count = count_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// Programmable VGA raster sequencer with shadowed timing committed at frame end.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW       = DEF_CW,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          pix_en,
  input  logic          enable,
  vga_timing_ctrl_if.slave cfg,
  output logic          H_pulse,
  output logic          V_pulse,
  output logic          active,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          line_start,
  output logic          frame_start
);

  function automatic logic [CW-1:0] default_field(input logic [2:0] sel);
    case (sel)
      SEL_H_ACT:  return CW'(H_ACTIVE);
      SEL_H_FP:   return CW'(H_FP);
      SEL_H_SYNC: return CW'(H_SYNC);
      SEL_H_BP:   return CW'(H_BP);
      SEL_V_ACT:  return CW'(V_ACTIVE);
      SEL_V_FP:   return CW'(V_FP);
      SEL_V_SYNC: return CW'(V_SYNC);
      default:    return CW'(V_BP);
    endcase
  endfunction

  logic [CW-1:0] live_q [8];
  logic [CW-1:0] live_d [8];
  logic [CW-1:0] shadow_q [8];
  logic [CW-1:0] shadow_d [8];
  logic          commit_pend_q, commit_pend_d;

  logic          tick, hold_origin, h_wrap, frame_end;
  phase_e        h_state, v_state;
  logic [CW-1:0] h_count, v_count;

  logic          h_pulse_q, h_pulse_d, v_pulse_q, v_pulse_d, active_q, active_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

  assign tick        = pix_en & enable;
  assign hold_origin = ~enable;

  vga_axis_seq #(.CW(CW)) u_h_seq (
    .clk     (CLK),
    .rst     (RST),
    .clr     (hold_origin),
    .adv     (tick),
    .len_act (live_q[SEL_H_ACT]),
    .len_fp  (live_q[SEL_H_FP]),
    .len_sync(live_q[SEL_H_SYNC]),
    .len_bp  (live_q[SEL_H_BP]),
    .state   (h_state),
    .count   (h_count),
    .wrap    (h_wrap)
  );

  vga_axis_seq #(.CW(CW)) u_v_seq (
    .clk     (CLK),
    .rst     (RST),
    .clr     (hold_origin),
    .adv     (h_wrap),
    .len_act (live_q[SEL_V_ACT]),
    .len_fp  (live_q[SEL_V_FP]),
    .len_sync(live_q[SEL_V_SYNC]),
    .len_bp  (live_q[SEL_V_BP]),
    .state   (v_state),
    .count   (v_count),
    .wrap    (frame_end)
  );

  assign cfg.cfg_ready = ~commit_pend_q;

  always_comb begin
    shadow_d      = shadow_q;
    live_d        = live_q;
    commit_pend_d = commit_pend_q;
    if (cfg.cfg_valid && !commit_pend_q) begin
      shadow_d[cfg.cfg_sel] = (cfg.cfg_data == '0) ? CW'(1) : cfg.cfg_data;
    end
    if (frame_end && commit_pend_q) begin
      live_d = shadow_q;
    end
    // a commit landing on the frame-end tick stays pending for the next frame end
    if (cfg.cfg_commit) begin
      commit_pend_d = 1'b1;
    end else if (frame_end) begin
      commit_pend_d = 1'b0;
    end
  end

  // Sequencer state names the pixel to present next; outputs register it on the tick.
  always_comb begin
    h_pulse_d     = h_pulse_q;
    v_pulse_d     = v_pulse_q;
    active_d      = active_q;
    col_d         = col_q;
    row_d         = row_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (!enable) begin
      h_pulse_d     = ~SYNC_POL;
      v_pulse_d     = ~SYNC_POL;
      active_d      = 1'b0;
      col_d         = '0;
      row_d         = '0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end else if (pix_en) begin
      h_pulse_d     = (h_state == SYNC) ? SYNC_POL : ~SYNC_POL;
      v_pulse_d     = (v_state == SYNC) ? SYNC_POL : ~SYNC_POL;
      active_d      = (h_state == ACT) && (v_state == ACT);
      col_d         = h_count;
      row_d         = v_count;
      line_start_d  = (h_state == ACT) && (h_count == '0);
      frame_start_d = line_start_d && (v_state == ACT) && (v_count == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 8; i++) begin
        live_q[i]   <= default_field(3'(i));
        shadow_q[i] <= default_field(3'(i));
      end
      commit_pend_q <= 1'b0;
      h_pulse_q     <= ~SYNC_POL;
      v_pulse_q     <= ~SYNC_POL;
      active_q      <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      live_q        <= live_d;
      shadow_q      <= shadow_d;
      commit_pend_q <= commit_pend_d;
      h_pulse_q     <= h_pulse_d;
      v_pulse_q     <= v_pulse_d;
      active_q      <= active_d;
      col_q         <= col_d;
      row_q         <= row_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign H_pulse     = h_pulse_q;
  assign V_pulse     = v_pulse_q;
  assign active      = active_q;
  assign col         = col_q;
  assign row         = row_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: pixel-index raster model plus directed and random steps.
module tb_vga_timing_ctrl;

  localparam int unsigned CW   = 10;
  localparam int unsigned P_HA = 20, P_HF = 4, P_HS = 6, P_HB = 5;
  localparam int unsigned P_VA = 12, P_VF = 2, P_VS = 3, P_VB = 4;
  localparam bit          POL  = 1'b0;
  localparam int unsigned FR   = (P_HA + P_HF + P_HS + P_HB) * (P_VA + P_VF + P_VS + P_VB);

  logic          CLK = 1'b0;
  logic          RST, pix_en, enable;
  logic          H_pulse, V_pulse, active, line_start, frame_start;
  logic [CW-1:0] col, row;

  vga_timing_ctrl_if #(.CW(CW)) cfg_if ();

  vga_timing_ctrl #(
    .CW(CW), .H_ACTIVE(P_HA), .H_FP(P_HF), .H_SYNC(P_HS), .H_BP(P_HB),
    .V_ACTIVE(P_VA), .V_FP(P_VF), .V_SYNC(P_VS), .V_BP(P_VB), .SYNC_POL(POL)
  ) dut (
    .CLK(CLK), .RST(RST), .pix_en(pix_en), .enable(enable), .cfg(cfg_if),
    .H_pulse(H_pulse), .V_pulse(V_pulse), .active(active), .col(col), .row(row),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  int unsigned defs [8] = '{P_HA, P_HF, P_HS, P_HB, P_VA, P_VF, P_VS, P_VB};
  int unsigned live [8];
  int unsigned shadow [8];
  int unsigned pos = 0;
  bit          pend = 1'b0;
  logic        e_h, e_v, e_act, e_ls, e_fs;
  int unsigned e_col, e_row;
  int unsigned ncyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL timeout_%s observed=expired expected=event", tag);
  endtask

  function automatic int unsigned hsum();
    return live[0] + live[1] + live[2] + live[3];
  endfunction

  function automatic int unsigned total();
    return hsum() * (live[4] + live[5] + live[6] + live[7]);
  endfunction

  task automatic split(input int unsigned x, input int unsigned a, input int unsigned b,
                       input int unsigned c, output int unsigned ph, output int unsigned off);
    if (x < a)              begin ph = 0; off = x;         end
    else if (x < a + b)     begin ph = 1; off = x - a;     end
    else if (x < a + b + c) begin ph = 2; off = x - a - b; end
    else                    begin ph = 3; off = x - a - b - c; end
  endtask

  task automatic reset_outs();
    e_h = !POL; e_v = !POL; e_act = 1'b0; e_col = 0; e_row = 0; e_ls = 1'b0; e_fs = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned hp, ho, vp, vo;
    bit fe, wr_ok;
    if (RST) begin
      live = defs; shadow = defs; pend = 1'b0; pos = 0;
      reset_outs();
      return;
    end
    wr_ok = !pend;
    fe = enable && pix_en && (pos == total() - 1);
    if (enable && pix_en) begin
      split(pos % hsum(), live[0], live[1], live[2], hp, ho);
      split(pos / hsum(), live[4], live[5], live[6], vp, vo);
      e_h   = (hp == 2) ? POL : !POL;
      e_v   = (vp == 2) ? POL : !POL;
      e_act = (hp == 0) && (vp == 0);
      e_col = ho;
      e_row = vo;
      e_ls  = (hp == 0) && (ho == 0);
      e_fs  = e_ls && (vp == 0) && (vo == 0);
      pos   = fe ? 0 : pos + 1;
    end else if (!enable) begin
      reset_outs();
      pos = 0;
    end
    if (fe && pend) live = shadow;
    if (cfg_if.cfg_valid && wr_ok)
      shadow[cfg_if.cfg_sel] = (cfg_if.cfg_data == 0) ? 1 : int'(cfg_if.cfg_data);
    if (cfg_if.cfg_commit) pend = 1'b1;
    else if (fe)           pend = 1'b0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
    model_edge();
    chk("H_pulse",     32'(H_pulse),          32'(e_h));
    chk("V_pulse",     32'(V_pulse),          32'(e_v));
    chk("active",      32'(active),           32'(e_act));
    chk("col",         32'(col),              e_col);
    chk("row",         32'(row),              e_row);
    chk("line_start",  32'(line_start),       32'(e_ls));
    chk("frame_start", 32'(frame_start),      32'(e_fs));
    chk("cfg_ready",   32'(cfg_if.cfg_ready), 32'(!pend));
    ncyc++;
  endtask

  task automatic write_cfg(input logic [2:0] sel, input int unsigned data);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_sel   = sel;
    cfg_if.cfg_data  = CW'(data);
    cycle();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_if.cfg_commit = 1'b1;
    cycle();
    cfg_if.cfg_commit = 1'b0;
  endtask

  task automatic run_until_pos(input int unsigned target, input string tag);
    int unsigned n = 0;
    while (pos != target) begin
      if (n == 5000) begin timeout(tag); return; end
      cycle();
      n++;
    end
  endtask

  task automatic wait_fs(input string tag);
    int unsigned n = 0;
    do begin
      if (n == 5000) begin timeout(tag); return; end
      cycle();
      n++;
    end while (frame_start !== 1'b1);
  endtask

  // Counts over one frame starting with the outputs already sampled.
  task automatic frame_stats(input int unsigned tot, input int unsigned ht,
                             output int unsigned act_c, output int unsigned hlow);
    act_c = (active === 1'b1) ? 1 : 0;
    hlow  = (H_pulse === POL) ? 1 : 0;
    for (int unsigned i = 1; i < tot; i++) begin
      cycle();
      if (active === 1'b1) act_c++;
      if (i < ht && H_pulse === POL) hlow++;
    end
  endtask

  initial begin
    int unsigned act_c, hlow, fs_at, fs_seen, fs_period, idle_bad, dis_cnt;
    live = defs; shadow = defs;
    reset_outs();
    RST = 1'b1; enable = 1'b1; pix_en = 1'b1;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_sel = '0; cfg_if.cfg_data = '0; cfg_if.cfg_commit = 1'b0;
    cycle();
    cycle();

    // default timing, tick every cycle
    RST = 1'b0;
    act_c = 0; fs_seen = 0; fs_at = 0; fs_period = 0;
    for (int unsigned i = 0; i < 2 * FR; i++) begin
      cycle();
      if (active === 1'b1) act_c++;
      if (frame_start === 1'b1) begin
        if (fs_seen == 1) fs_period = ncyc - fs_at;
        fs_at = ncyc;
        fs_seen++;
      end
    end
    chk("fs_period", fs_period, FR);
    chk("active_2frames", act_c, 2 * P_HA * P_VA);

    // tick every 4th cycle
    act_c = 0;
    for (int unsigned i = 0; i < 4 * FR; i++) begin
      pix_en = (i % 4 == 0);
      cycle();
      if (pix_en && active === 1'b1) act_c++;
    end
    pix_en = 1'b1;
    chk("active_div4", act_c, P_HA * P_VA);

    // mid-frame H_ACT change applies at the next frame
    run_until_pos(5 * hsum(), "line5");
    write_cfg(3'd0, 10);
    commit();
    wait_fs("commit_hact");
    frame_stats(25 * 21, 25, act_c, hlow);
    chk("active_hact10", act_c, 10 * P_VA);

    // zero-length sync becomes 1; writes while pending are dropped
    write_cfg(3'd2, 0);
    commit();
    write_cfg(3'd4, 3);
    wait_fs("commit_hsync");
    frame_stats(20 * 21, 20, act_c, hlow);
    chk("hsync_len1", hlow, 1);
    chk("vact_unchanged", act_c, 10 * P_VA);

    // commit on the frame-end tick waits for the following frame end
    write_cfg(3'd0, 15);
    run_until_pos(total() - 1, "frame_end");
    commit();
    cycle();
    frame_stats(20 * 21, 20, act_c, hlow);
    chk("late_commit_old", act_c, 10 * P_VA);
    cycle();
    frame_stats(25 * 21, 25, act_c, hlow);
    chk("late_commit_new", act_c, 15 * P_VA);

    // reset mid-line returns to defaults
    run_until_pos(5 * hsum() + 7, "rst_point");
    RST = 1'b1;
    cycle();
    chk("rst_col", 32'(col), 0);
    chk("rst_hpulse", 32'(H_pulse), 32'(!POL));
    RST = 1'b0;
    cycle();
    chk("rst_first_fs", 32'(frame_start), 1);
    frame_stats(FR, 35, act_c, hlow);
    chk("rst_defaults_active", act_c, P_HA * P_VA);

    // enable low mid-frame holds the origin, restart uses programmed timing
    write_cfg(3'd0, 14);
    commit();
    wait_fs("commit_en");
    run_until_pos(3 * hsum() + 2, "en_point");
    enable = 1'b0;
    idle_bad = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      cycle();
      if (H_pulse !== !POL || V_pulse !== !POL || active !== 1'b0) idle_bad++;
    end
    chk("disabled_idle", idle_bad, 0);
    enable = 1'b1;
    cycle();
    chk("en_first_fs", 32'(frame_start), 1);
    chk("en_first_col", 32'(col), 0);
    frame_stats(29 * 21, 29, act_c, hlow);
    chk("en_active", act_c, 14 * P_VA);

    // randomized traffic
    dis_cnt = 0;
    for (int unsigned i = 0; i < 6000; i++) begin
      pix_en            = ($urandom_range(0, 2) != 0);
      cfg_if.cfg_valid  = ($urandom_range(0, 9) == 0);
      cfg_if.cfg_sel    = 3'($urandom_range(0, 7));
      cfg_if.cfg_data   = CW'($urandom_range(0, 6));
      cfg_if.cfg_commit = ($urandom_range(0, 49) == 0);
      RST               = ($urandom_range(0, 1999) == 0);
      if (dis_cnt > 0) dis_cnt--;
      else if ($urandom_range(0, 299) == 0) dis_cnt = $urandom_range(1, 20);
      enable = (dis_cnt == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
